cc_level_sequencer: RTL and testbench



---
 rtl/cc_level_sequencer_pkg.sv | 15 +
 rtl/cc_level_sequencer_edge.sv | 19 +
 rtl/cc_level_sequencer.sv | 140 ++++++++++++++
 tb/tb_cc_level_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cc_level_sequencer_pkg.sv
// Shared state codes and default timing for the Frogger level sequencer.
package cc_level_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // One second of board freeze at 50 MHz.
  localparam int PAUSE_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/cc_level_sequencer_edge.sv
// Falling-edge detector: one-cycle fall pulse when din goes 1 -> 0.
// The pulse is valid in the same cycle the low level is first seen.
module cc_falling_edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 1'b1;
    else        hist <= din;
  end

  assign fall = hist & ~din;

endmodule

// File: rtl/cc_level_sequencer.sv
// Frogger level sequencer: owns the level register, the inter-level pause
// and the win / game-over decisions.
//
// state | meaning
// IDLE  | after reset, waiting for the first start press
// PLAY  | board running, goal advances the level
// PAUSE | board frozen for PAUSE_CYCLES after a level-up
// WIN   | final level cleared, waiting for start
// OVER  | lives exhausted, waiting for start
module cc_level_sequencer
  import cc_level_sequencer_pkg::*;
#(
  parameter int LEVELS_DATAWIDTH = 2,
  parameter int PAUSE_CYCLES     = PAUSE_CYCLES_DEFAULT,
  parameter int PAUSE_WIDTH      = 26
) (
  input  logic                        CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                        CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                        CC_LEVEL_SEQUENCER_start_InLow,
  input  logic                        CC_LEVEL_SEQUENCER_goal_InLow,
  input  logic                        CC_LEVEL_SEQUENCER_gameover_InLow,
  output logic [LEVELS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_level_OutBUS,
  output logic                        CC_LEVEL_SEQUENCER_levelup_OutLow,
  output logic                        CC_LEVEL_SEQUENCER_freeze_OutLow,
  output logic                        CC_LEVEL_SEQUENCER_win_OutLow,
  output logic [2:0]                  CC_LEVEL_SEQUENCER_state_OutBUS
);

  localparam logic [LEVELS_DATAWIDTH-1:0] MAX_LEVEL  = '1;
  localparam logic [PAUSE_WIDTH-1:0]      PAUSE_LOAD = PAUSE_WIDTH'(PAUSE_CYCLES - 1);

  logic clk;
  logic rst_n;
  assign clk   = CC_LEVEL_SEQUENCER_CLOCK_50;
  assign rst_n = CC_LEVEL_SEQUENCER_RESET_InLow;

  logic start_fall;
  logic goal_fall;
  logic over_fall;

  cc_falling_edge_detector u_start_edge (
    .clk (clk),
    .rst_n (rst_n),
    .din (CC_LEVEL_SEQUENCER_start_InLow),
    .fall (start_fall)
  );

  cc_falling_edge_detector u_goal_edge (
    .clk (clk),
    .rst_n (rst_n),
    .din (CC_LEVEL_SEQUENCER_goal_InLow),
    .fall (goal_fall)
  );

  cc_falling_edge_detector u_over_edge (
    .clk (clk),
    .rst_n (rst_n),
    .din (CC_LEVEL_SEQUENCER_gameover_InLow),
    .fall (over_fall)
  );

  state_t                      state_q, state_d;
  logic [LEVELS_DATAWIDTH-1:0] level_q, level_d;
  logic [PAUSE_WIDTH-1:0]      cnt_q, cnt_d;
  logic                        levelup_q, levelup_d;
  logic                        freeze_q, freeze_d;
  logic                        win_q, win_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      cnt_q     <= '0;
      levelup_q <= 1'b1;
      freeze_q  <= 1'b0;
      win_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      levelup_q <= levelup_d;
      freeze_q  <= freeze_d;
      win_q     <= win_d;
    end
  end

  // Gameover outranks goal; the increment is only issued below MAX_LEVEL.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_fall) begin
          state_d = ST_PLAY;
          level_d = '0;
        end
      end
      ST_PLAY: begin
        if (over_fall) begin
          state_d = ST_OVER;
        end else if (goal_fall) begin
          if (level_q < MAX_LEVEL) begin
            level_d = level_q + 1'b1;
            cnt_d   = PAUSE_LOAD;
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_WIN;
          end
        end
      end
      ST_PAUSE: begin
        if (over_fall)          state_d = ST_OVER;
        else if (cnt_q == '0)   state_d = ST_PLAY;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      ST_WIN, ST_OVER: begin
        if (start_fall) begin
          state_d = ST_PLAY;
          level_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PLAY -> PAUSE only happens on a level increment, so it marks the pulse.
  always_comb begin
    levelup_d = ~((state_q == ST_PLAY) && (state_d == ST_PAUSE));
    freeze_d  = (state_d == ST_PLAY);
    win_d     = (state_d != ST_WIN);
  end

  assign CC_LEVEL_SEQUENCER_level_OutBUS    = level_q;
  assign CC_LEVEL_SEQUENCER_levelup_OutLow  = levelup_q;
  assign CC_LEVEL_SEQUENCER_freeze_OutLow   = freeze_q;
  assign CC_LEVEL_SEQUENCER_win_OutLow      = win_q;
  assign CC_LEVEL_SEQUENCER_state_OutBUS    = state_q;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Scoreboard bench for cc_level_sequencer: directed game scenarios followed by
// random button/goal/gameover traffic, all checked against a behavioural model.
module tb_cc_level_sequencer;

  localparam int LW   = 2;
  localparam int PC   = 4;
  localparam int PW   = 3;
  localparam int MAXL = 3;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic start_n = 1'b1;
  logic goal_n  = 1'b1;
  logic over_n  = 1'b1;

  logic [LW-1:0] level;
  logic          levelup;
  logic          freeze;
  logic          win;
  logic [2:0]    state;

  cc_level_sequencer #(
    .LEVELS_DATAWIDTH (LW),
    .PAUSE_CYCLES (PC),
    .PAUSE_WIDTH (PW)
  ) dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50 (clk),
    .CC_LEVEL_SEQUENCER_RESET_InLow (rst_n),
    .CC_LEVEL_SEQUENCER_start_InLow (start_n),
    .CC_LEVEL_SEQUENCER_goal_InLow (goal_n),
    .CC_LEVEL_SEQUENCER_gameover_InLow (over_n),
    .CC_LEVEL_SEQUENCER_level_OutBUS (level),
    .CC_LEVEL_SEQUENCER_levelup_OutLow (levelup),
    .CC_LEVEL_SEQUENCER_freeze_OutLow (freeze),
    .CC_LEVEL_SEQUENCER_win_OutLow (win),
    .CC_LEVEL_SEQUENCER_state_OutBUS (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  // Reference model: game mode by its display code, level as an integer and
  // the number of frozen cycles still to serve.
  int   m_mode;
  int   m_level;
  int   m_pause_left;
  logic m_prev_s, m_prev_g, m_prev_o;
  logic m_levelup;

  task automatic model_reset();
    m_mode       = 0;
    m_level      = 0;
    m_pause_left = 0;
    m_prev_s     = 1'b1;
    m_prev_g     = 1'b1;
    m_prev_o     = 1'b1;
    m_levelup    = 1'b1;
  endtask

  task automatic model_step(input logic s, input logic g, input logic o);
    logic start_ev, goal_ev, over_ev;
    start_ev  = m_prev_s && !s;
    goal_ev   = m_prev_g && !g;
    over_ev   = m_prev_o && !o;
    m_prev_s  = s;
    m_prev_g  = g;
    m_prev_o  = o;
    m_levelup = 1'b1;
    if (m_mode == 0 || m_mode == 3 || m_mode == 4) begin
      if (start_ev) begin
        m_mode  = 1;
        m_level = 0;
      end
    end else if (m_mode == 1) begin
      if (over_ev) m_mode = 4;
      else if (goal_ev) begin
        if (m_level < MAXL) begin
          m_level      = m_level + 1;
          m_levelup    = 1'b0;
          m_pause_left = PC;
          m_mode       = 2;
        end else begin
          m_mode = 3;
        end
      end
    end else if (m_mode == 2) begin
      if (over_ev) m_mode = 4;
      else begin
        m_pause_left = m_pause_left - 1;
        if (m_pause_left == 0) m_mode = 1;
      end
    end
  endtask

  function automatic logic [7:0] model_pack();
    logic fz, wn;
    fz = (m_mode == 1);
    wn = (m_mode != 3);
    return {3'(m_mode), 2'(m_level), m_levelup, fz, wn};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got st=%0d lvl=%0d lu=%b fz=%b win=%b, want st=%0d lvl=%0d lu=%b fz=%b win=%b",
               name, $time, got[7:5], got[4:3], got[2], got[1], got[0],
               want[7:5], want[4:3], want[2], want[1], want[0]);
    end
  endtask

  // Monitor: the DUT presents fresh registered outputs after every clock edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0)
      check("cycle_out", {state, level, levelup, freeze, win}, exp_q.pop_front());
  end

  task automatic cyc(input logic s, input logic g, input logic o);
    @(negedge clk);
    start_n = s;
    goal_n  = g;
    over_n  = o;
    model_step(s, g, o);
    exp_q.push_back(model_pack());
  endtask

  task automatic hold(input logic s, input logic g, input logic o, input int n);
    for (int i = 0; i < n; i++) cyc(s, g, o);
  endtask

  task automatic goal_pulse();
    cyc(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b1, 1'b1, PC + 2);
  endtask

  task automatic start_pulse();
    cyc(1'b0, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 1'b1, 2);
  endtask

  // Reset asserted between edges must clear outputs with no clock.
  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    start_n = 1'b1;
    goal_n  = 1'b1;
    over_n  = 1'b1;
    #1;
    model_reset();
    check("async_reset", {state, level, levelup, freeze, win}, model_pack());
    @(negedge clk);
    @(negedge clk);
    check("reset_held", {state, level, levelup, freeze, win}, model_pack());
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: run still active at %0t, want finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #20;
    check("power_on_reset", {state, level, levelup, freeze, win}, model_pack());
    @(negedge clk);
    rst_n = 1'b1;

    hold(1'b1, 1'b1, 1'b1, 2);
    hold(1'b0, 1'b1, 1'b1, 3);          // held start: one transition only
    hold(1'b1, 1'b1, 1'b1, 1);
    hold(1'b1, 1'b0, 1'b1, 10);         // held goal: one level-up, full pause
    hold(1'b1, 1'b1, 1'b1, 2);
    goal_pulse();
    goal_pulse();
    goal_pulse();                       // at MAX_LEVEL: WIN, no pulse
    goal_pulse();                       // ignored in WIN
    start_pulse();

    goal_pulse();
    goal_pulse();
    cyc(1'b1, 1'b0, 1'b0);              // goal and gameover together
    hold(1'b1, 1'b1, 1'b1, 3);
    goal_pulse();                       // ignored in OVER
    start_pulse();

    cyc(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b1, 1'b1, 1);
    cyc(1'b1, 1'b1, 1'b0);              // gameover during pause
    hold(1'b1, 1'b1, 1'b1, 3);
    start_pulse();

    goal_pulse();
    cyc(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b1, 1'b1, 2);
    async_reset_check();
    hold(1'b1, 1'b1, 1'b1, 3);
    start_pulse();

    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 15) != 0),
          logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 40) != 0));
    end
    hold(1'b1, 1'b1, 1'b1, 2);

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
